// File: rtl/f1_window_fetch.sv
// f1_window_fetch: scans the layer-1 feature map in f1_ram and streams every
// KxK window (stride 1, no padding) in raster order to the conv1 MAC array.
// The RAM read latency is covered by a valid/tag shift register. A small
// output FIFO is guarded by a credit check on issue, so downstream stalls
// never lose data.
module f1_window_fetch #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] f1_raddr,
    input  logic [7:0]        f1_rdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_win_last,
    output logic              pix_frame_last
);

    localparam int OH    = IMG_H - K + 1;
    localparam int OW    = IMG_W - K + 1;
    localparam int ROW_W = $clog2(OH + 1);
    localparam int COL_W = $clog2(OW + 1);
    localparam int KW    = $clog2(K + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           orow_q, orow_d;
    logic [COL_W-1:0]           ocol_q, ocol_d;
    logic [KW-1:0]              kr_q, kr_d;
    logic [KW-1:0]              kc_q, kc_d;
    logic [ADDR_W-1:0]          raddr_q, raddr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [RD_LAT-1:0]          vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0][1:0]     tag_sr_q, tag_sr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [9:0]                 fifo_mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0]           inflight;
    logic [ADDR_W-1:0]          scan_addr;
    logic                       win_last, frame_last, credit_ok, issue;
    logic                       push, pop;
    logic [1:0]                 push_tag;
    logic [9:0]                 head;

    // Wrap a FIFO pointer at the (possibly non power-of-two) depth.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads in flight = occupied slots of the latency shift register.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_sr_q[i]);
        end
    end

    // Window position to RAM address, plus the tag bits for this position.
    always_comb begin
        scan_addr  = ADDR_W'((int'(orow_q) + int'(kr_q)) * IMG_W + int'(ocol_q) + int'(kc_q));
        win_last   = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
        frame_last = win_last && (orow_q == ROW_W'(OH - 1)) && (ocol_q == COL_W'(OW - 1));
        // Counts are taken before this cycle's pushes/pops, so a same-cycle pop
        // only frees credit on the next cycle.
        credit_ok  = ({1'b0, fifo_cnt_q} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    end

    // Control FSM: scan counters, issue decision, busy/done generation.
    always_comb begin
        state_d = state_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        raddr_d = raddr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    orow_d  = '0;
                    ocol_d  = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    raddr_d = scan_addr;
                    // Innermost kc, then kr, ocol, orow; all wrap to 0 after the final issue.
                    if (kc_q == KW'(K - 1)) begin
                        kc_d = '0;
                        if (kr_q == KW'(K - 1)) begin
                            kr_d = '0;
                            if (ocol_q == COL_W'(OW - 1)) begin
                                ocol_d = '0;
                                orow_d = (orow_q == ROW_W'(OH - 1)) ? '0 : orow_q + 1'b1;
                            end else begin
                                ocol_d = ocol_q + 1'b1;
                            end
                        end else begin
                            kr_d = kr_q + 1'b1;
                        end
                    end else begin
                        kc_d = kc_q + 1'b1;
                    end
                    if (frame_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((fifo_cnt_q == '0) && (inflight == '0)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latency shift register for read valid and {win_last, frame_last} tags.
    always_comb begin
        vld_sr_d    = '0;
        tag_sr_d    = '0;
        vld_sr_d[0] = issue;
        tag_sr_d[0] = {win_last, frame_last};
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    // Output FIFO bookkeeping: RAM data lands when the shift register's last stage is valid.
    always_comb begin
        push       = vld_sr_q[RD_LAT-1];
        push_tag   = tag_sr_q[RD_LAT-1];
        pop        = pix_valid && pix_ready;
        wr_ptr_d   = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control and address state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            orow_q     <= '0;
            ocol_q     <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            raddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_sr_q   <= '0;
            tag_sr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            raddr_q    <= raddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_sr_q   <= vld_sr_d;
            tag_sr_q   <= tag_sr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful while the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {push_tag, f1_rdata};
        end
    end

    // Outputs are forced to zero whenever the FIFO is empty.
    always_comb begin
        head           = fifo_mem_q[rd_ptr_q];
        pix_valid      = (fifo_cnt_q != '0);
        pix_data       = pix_valid ? head[7:0] : 8'd0;
        pix_win_last   = pix_valid & head[9];
        pix_frame_last = pix_valid & head[8];
        f1_raddr       = raddr_q;
        busy           = busy_q;
        done           = done_q;
    end

endmodule
